// File: rtl/bias_add_0_pkg.sv
// Shared layer-0 constants and types for the bias adder.
// Holds the channel count, pixel count, datapath widths and the shift
// that the conv_0 layer uses. Also defines the FSM state type and a
// counter-width helper.
package bias_add_0_pkg;

  localparam int KERN_S_K_0   = 16;    // output channels per pixel
  localparam int CONV_0_PIX   = 1024;  // output pixels per frame
  localparam int ACC_WIDTH    = 32;    // signed accumulator width
  localparam int COEFF_WIDTH  = 16;    // signed bias width
  localparam int ACT_WIDTH    = 16;    // signed activation width
  localparam int CONV_0_SHIFT = 8;     // post-add arithmetic right shift

  typedef enum logic {
    ST_LOAD = 1'b0,  // capturing the K biases for the next frame
    ST_RUN  = 1'b1   // streaming accumulator words through the adder
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_add_0_sat_shift.sv
// bias_sat_shift: combinational add, floor shift, optional ReLU and saturate.
// Ports:
//   acc_i   in  ACC_W    signed accumulator word
//   bias_i  in  COEFF_W  signed bias for the word's channel
//   res_o   out OUT_W    signed, rescaled and saturated result
// The sum is formed one bit wider than the accumulator, so adding the bias
// can never wrap. Requires COEFF_W <= ACC_W and OUT_W <= ACC_W.
module bias_sat_shift
  import bias_add_0_pkg::*;
#(
  parameter int ACC_W   = ACC_WIDTH,
  parameter int COEFF_W = COEFF_WIDTH,
  parameter int OUT_W   = ACT_WIDTH,
  parameter int SHIFT   = CONV_0_SHIFT,
  parameter int RELU    = 0
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic signed [COEFF_W-1:0] bias_i,
  output logic signed [OUT_W-1:0]   res_o
);

  localparam int SW = ACC_W + 1;

  localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Widened add, then arithmetic shift: rounds toward minus infinity.
  function automatic logic signed [SW-1:0] add_shift(
    input logic signed [ACC_W-1:0]   a,
    input logic signed [COEFF_W-1:0] b
  );
    logic signed [SW-1:0] s;
    s = {a[ACC_W-1], a} + {{(SW-COEFF_W){b[COEFF_W-1]}}, b};
    return s >>> SHIFT;
  endfunction

  // Optional ReLU, then clamp into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] relu_sat(input logic signed [SW-1:0] r);
    logic signed [SW-1:0] v;
    v = r;
    if ((RELU != 0) && (v < 0)) v = '0;
    if (v > MAX_V)      return MAX_V[OUT_W-1:0];
    else if (v < MIN_V) return MIN_V[OUT_W-1:0];
    else                return v[OUT_W-1:0];
  endfunction

  always_comb begin
    res_o = relu_sat(add_shift(acc_i, bias_i));
  end

endmodule

// File: rtl/bias_add_0.sv
// bias_add_0: layer-0 bias adder between the conv_0 MAC stream and the
// activation FIFO.
// Ports:
//   ap_clk, ap_rst                        clock; async active-high reset
//   bias_V_dout/_empty_n/_read            bias FIFO (K words per frame)
//   acc_V_dout/_empty_n/_read             accumulator FIFO, channel-innermost
//   output_V_din/_full_n/_write           activation FIFO
// LOAD captures K biases. RUN adds breg[ch] to each accumulator word through
// a single output register. The last result of a frame may still be waiting
// on a full output FIFO while LOAD pops the next frame's biases. That is
// safe because the result was already computed and registered.
module bias_add_0
  import bias_add_0_pkg::*;
#(
  parameter int K       = KERN_S_K_0,
  parameter int N_PIX   = CONV_0_PIX,
  parameter int ACC_W   = ACC_WIDTH,
  parameter int COEFF_W = COEFF_WIDTH,
  parameter int OUT_W   = ACT_WIDTH,
  parameter int SHIFT   = CONV_0_SHIFT,
  parameter int RELU    = 0
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic signed [COEFF_W-1:0] bias_V_dout,
  input  logic                      bias_V_empty_n,
  output logic                      bias_V_read,
  input  logic signed [ACC_W-1:0]   acc_V_dout,
  input  logic                      acc_V_empty_n,
  output logic                      acc_V_read,
  output logic signed [OUT_W-1:0]   output_V_din,
  input  logic                      output_V_full_n,
  output logic                      output_V_write
);

  localparam int CH_W  = cnt_w(K);
  localparam int PIX_W = cnt_w(N_PIX);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(K - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
  logic                      vld_p1_q, vld_p1_d;
  logic signed [OUT_W-1:0]   res_p1_q, res_p1_d;
  logic signed [COEFF_W-1:0] breg_q [K];

  logic                      adv;
  logic                      bias_pop;
  logic                      acc_pop;
  logic signed [COEFF_W-1:0] bias_sel;
  logic signed [OUT_W-1:0]   res_f;

  assign bias_sel = breg_q[ch_cnt_q];

  bias_sat_shift #(
    .ACC_W  (ACC_W),
    .COEFF_W(COEFF_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .RELU   (RELU)
  ) u_sat_shift (
    .acc_i (acc_V_dout),
    .bias_i(bias_sel),
    .res_o (res_f)
  );

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    vld_p1_d  = vld_p1_q;
    res_p1_d  = res_p1_q;
    bias_pop  = 1'b0;
    acc_pop   = 1'b0;
    // The output register frees whenever it is empty or being drained.
    // This holds in both states, so the frame's last word drains during LOAD.
    adv = !vld_p1_q || output_V_full_n;
    if (adv) vld_p1_d = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        // Reset blocks the pop: the state reads LOAD while ap_rst is high.
        bias_pop = bias_V_empty_n && !ap_rst;
        if (bias_pop) begin
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            state_d  = ST_RUN;
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        acc_pop = acc_V_empty_n && adv;
        if (acc_pop) begin
          res_p1_d = res_f;
          vld_p1_d = 1'b1;
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d = '0;
              state_d   = ST_LOAD;
            end else begin
              pix_cnt_d = pix_cnt_q + 1'b1;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // ---- stage p1: output register and control ----
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= ST_LOAD;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      vld_p1_q  <= 1'b0;
      res_p1_q  <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      vld_p1_q  <= vld_p1_d;
      res_p1_q  <= res_p1_d;
    end
  end

  // Bias register file: plain data, so it has no reset.
  always_ff @(posedge ap_clk) begin
    if (bias_pop) breg_q[ch_cnt_q] <= bias_V_dout;
  end

  assign bias_V_read    = bias_pop;
  assign acc_V_read     = acc_pop;
  assign output_V_din   = res_p1_q;
  assign output_V_write = vld_p1_q && output_V_full_n;

endmodule
